spi_adc_responder: RTL and testbench

- Synthesizable model of the MCP3008-style serial ADC, i.e. the device end of the ADC serial link.
- It answers the cs/Din/Dout conversion protocol: it decodes the start bit and the 4-bit command, then shifts back a null bit and a 10-bit sample, MSB first.
- Used in loopback builds and testbenches in place of the physical ADC. Channel values come from a parallel input bus.
- All serial inputs are oversampled in the single clk domain.

---
 rtl/adc_pkg.sv | 28 ++
 rtl/spi_adc_responder_sync_edge_detect.sv | 44 ++++
 rtl/spi_adc_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_adc_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared constants and state encodings for the serial ADC
//                responder (MCP3008-style device end of the link).
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    // Command word after the start bit: SGL/DIFF, D2, D1, D0
    localparam int CMD_BITS   = 4;
    // Default sample width and channel count of the modelled converter
    localparam int ADC_DATA_W = 10;
    localparam int ADC_NUM_CH = 8;

    // Conversion state machine encodings
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] adc_state_t;

    localparam adc_state_t S_IDLE       = 3'd0;
    localparam adc_state_t S_WAIT_START = 3'd1;
    localparam adc_state_t S_CMD        = 3'd2;
    localparam adc_state_t S_NULL       = 3'd3;
    localparam adc_state_t S_DATA       = 3'd4;
    localparam adc_state_t S_DONE       = 3'd5;

endpackage : adc_pkg
`default_nettype wire

// File: rtl/spi_adc_responder_sync_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_detect
//  Description : Multi-flop synchronizer for one asynchronous input, with
//                one-cycle rise/fall strobes derived from the last two
//                synchronized samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // Fewer than two flops gives no metastability protection, so clamp
    localparam int C_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [C_STAGES-1:0] sync_q;
    logic                prev_q;

    // Shift the pin value through the synchronizer chain and keep one
    // extra sample of the synchronized level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {C_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[C_STAGES-2:0], d_i};
            prev_q <= sync_q[C_STAGES-1];
        end
    end

    assign level_o = sync_q[C_STAGES-1];
    assign rise_o  =  sync_q[C_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[C_STAGES-1] &  prev_q;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/spi_adc_responder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_adc_responder
//  Description : Device end of an MCP3008-style serial ADC link. Decodes the
//                start bit and 4-bit command on din, then returns a null bit
//                followed by a DATA_W-bit channel sample on dout, MSB first.
//                All serial pins are oversampled in the clk domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_adc_responder
    import adc_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int NUM_CH      = ADC_NUM_CH,
    parameter int CH_W        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclk_i,
    input  logic                     cs_i,
    input  logic                     din_i,
    output logic                     dout_o,
    output logic                     dout_oe_o,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    output logic [CH_W-1:0]          ch_sel_o,
    output logic                     single_ended_o,
    output logic                     conv_done_o
);

    // The bit counter indexes both the command bits and the data bits
    localparam int C_CNT_W = (DATA_W > CMD_BITS) ? $clog2(DATA_W) : $clog2(CMD_BITS);
    localparam logic [C_CNT_W-1:0] C_CNT_CMD_LAST  = C_CNT_W'(CMD_BITS - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_DATA_LAST = C_CNT_W'(DATA_W - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_cs_s,   w_cs_rise,   w_cs_fall;
    logic w_din_s,  w_din_rise,  w_din_fall;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .d_i     (sclk_i),
        .level_o (w_sclk_s),
        .rise_o  (w_sclk_rise),
        .fall_o  (w_sclk_fall)
    );

    // cs resets high so the responder starts deselected
    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .d_i     (cs_i),
        .level_o (w_cs_s),
        .rise_o  (w_cs_rise),
        .fall_o  (w_cs_fall)
    );

    // din goes through the same depth as sclk so it stays aligned with
    // the sclk edge strobes
    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sync_din (
        .clk     (clk),
        .rst     (rst),
        .d_i     (din_i),
        .level_o (w_din_s),
        .rise_o  (w_din_rise),
        .fall_o  (w_din_fall)
    );

    // Only the sclk strobes and the cs/din levels drive decisions
    logic w_unused_sync;
    assign w_unused_sync = ^{w_sclk_s, w_cs_rise, w_cs_fall, w_din_rise, w_din_fall};

    // ------------------------------------------------------------------
    // Channel unpacking
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_ch [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_ch[k] = ch_data_i[k*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // Conversion state machine
    // ------------------------------------------------------------------
    adc_state_t          state_q,  state_d;
    logic [C_CNT_W-1:0]  cnt_q,    cnt_d;
    logic [CMD_BITS-1:0] cmd_q,    cmd_d;
    logic [DATA_W-1:0]   shift_q,  shift_d;
    logic                dout_q,   dout_d;
    logic                oe_q,     oe_d;
    logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
    logic                sgl_q,    sgl_d;
    logic                done_q,   done_d;

    // Command register as it will look after the current din is shifted in;
    // on the last command bit this is the complete command word
    logic [CMD_BITS-1:0] w_cmd_next;
    assign w_cmd_next = {cmd_q[CMD_BITS-2:0], w_din_s};

    // Next-state and output decode; a deselect overrides any sclk edge
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        shift_d  = shift_q;
        dout_d   = dout_q;
        oe_d     = oe_q;
        ch_sel_d = ch_sel_q;
        sgl_d    = sgl_q;
        done_d   = 1'b0;

        if (w_cs_s) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            dout_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Selected: start driving dout low while hunting for start
                    oe_d    = 1'b1;
                    dout_d  = 1'b0;
                    state_d = S_WAIT_START;
                end

                S_WAIT_START: begin
                    oe_d   = 1'b1;
                    dout_d = 1'b0;
                    // Leading zeros are skipped; the first 1 is the start bit
                    if (w_sclk_rise && w_din_s) begin
                        cnt_d   = '0;
                        cmd_d   = '0;
                        state_d = S_CMD;
                    end
                end

                S_CMD: begin
                    if (w_sclk_rise) begin
                        cmd_d = w_cmd_next;
                        if (cnt_q == C_CNT_CMD_LAST) begin
                            sgl_d    = w_cmd_next[CMD_BITS-1];
                            ch_sel_d = w_cmd_next[CH_W-1:0];
                            // Snapshot now so later ch_data changes cannot
                            // corrupt the word being returned
                            shift_d  = w_ch[w_cmd_next[CH_W-1:0]];
                            cnt_d    = '0;
                            state_d  = S_NULL;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end

                S_NULL: begin
                    if (w_sclk_fall) begin
                        dout_d  = 1'b0;
                        cnt_d   = C_CNT_DATA_LAST;
                        state_d = S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_sclk_fall) begin
                        dout_d  = shift_q[DATA_W-1];
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        if (cnt_q == '0) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // Idle low until the initiator deselects
                    if (w_sclk_fall) begin
                        dout_d = 1'b0;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                    dout_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            shift_q  <= '0;
            dout_q   <= 1'b0;
            oe_q     <= 1'b0;
            ch_sel_q <= '0;
            sgl_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            shift_q  <= shift_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            ch_sel_q <= ch_sel_d;
            sgl_q    <= sgl_d;
            done_q   <= done_d;
        end
    end

    assign dout_o         = dout_q;
    assign dout_oe_o      = oe_q;
    assign ch_sel_o       = ch_sel_q;
    assign single_ended_o = sgl_q;
    assign conv_done_o    = done_q;

endmodule : spi_adc_responder
`default_nettype wire

// File: tb/tb_spi_adc_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_adc_responder
//  Description : Directed, table-driven bench for spi_adc_responder. Acts as
//                the serial initiator with sclk = clk/8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_adc_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        din = 1'b0;
    logic        dout;
    logic        dout_oe;
    logic [79:0] ch_data = '0;
    logic [2:0]  ch_sel;
    logic        single_ended;
    logic        conv_done;

    int total = 0;
    int bad   = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    spi_adc_responder #(
        .DATA_W      (10),
        .NUM_CH      (8),
        .CH_W        (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sclk_i         (sclk),
        .cs_i           (cs),
        .din_i          (din),
        .dout_o         (dout),
        .dout_oe_o      (dout_oe),
        .ch_data_i      (ch_data),
        .ch_sel_o       (ch_sel),
        .single_ended_o (single_ended),
        .conv_done_o    (conv_done)
    );

    // Count conv_done cycles; a stretched pulse shows up as a count > 1
    always @(negedge clk) begin
        if (conv_done) n_done <= n_done + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Addressed channel gets v; every other channel a distinct filler value
    task automatic set_channels(input int ch, input logic [9:0] v);
        for (int k = 0; k < 8; k++) ch_data[k*10 +: 10] = 10'h3C0 ^ 10'(k);
        ch_data[ch*10 +: 10] = v;
    endtask

    // One initiator frame of n_clk sclk periods. got collects dout sampled at
    // each sclk rise from the null bit on (null ends up in bit 10 of a full
    // frame). At clock chg_idx the addressed channel's value is replaced.
    task automatic frame(input int lead, input bit sgl, input int ch, input int n_clk,
                         input bit end_cs, input int chg_idx, input logic [9:0] chg_val,
                         output logic [10:0] got, output logic oe_mid);
        logic [4:0] hdr;
        hdr    = {1'b1, sgl, 3'(ch)};
        got    = '0;
        oe_mid = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n_clk; i++) begin
            if (i == chg_idx) ch_data[ch*10 +: 10] = chg_val;
            if (i >= lead && i < lead + 5) din = hdr[4 - (i - lead)];
            else                           din = 1'b0;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            if (i >= lead + 5) got = {got[9:0], dout};
            if (i == lead + 5) oe_mid = dout_oe;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        if (end_cs) begin
            cs  = 1'b1;
            din = 1'b0;
        end
    endtask

    typedef struct {
        int         lead;
        bit         sgl;
        int         ch;
        logic [9:0] val;
        logic [9:0] exp_word;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [10:0] got;
        logic        oe_mid;
        int          n0;

        vecs[0] = '{lead: 0, sgl: 1'b1, ch: 5, val: 10'h2A5, exp_word: 10'b1010100101};
        vecs[1] = '{lead: 3, sgl: 1'b1, ch: 0, val: 10'h3FF, exp_word: 10'b1111111111};
        vecs[2] = '{lead: 0, sgl: 1'b0, ch: 3, val: 10'h001, exp_word: 10'b0000000001};
        vecs[3] = '{lead: 1, sgl: 1'b1, ch: 2, val: 10'h155, exp_word: 10'b0101010101};
        vecs[4] = '{lead: 0, sgl: 1'b0, ch: 6, val: 10'h2C3, exp_word: 10'b1011000011};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_dout",    32'(dout), 0);
        check("rst_oe",      32'(dout_oe), 0);
        check("rst_ch_sel",  32'(ch_sel), 0);
        check("rst_sgl",     32'(single_ended), 0);
        check("rst_done",    32'(conv_done), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_oe", 32'(dout_oe), 0);

        // Table-driven full frames
        for (int v = 0; v < 5; v++) begin
            set_channels(vecs[v].ch, vecs[v].val);
            n0 = n_done;
            frame(vecs[v].lead, vecs[v].sgl, vecs[v].ch, vecs[v].lead + 16, 1'b1, -1, 10'h0, got, oe_mid);
            check($sformatf("v%0d_null", v),   32'(got[10]), 0);
            check($sformatf("v%0d_word", v),   32'(got[9:0]), 32'(vecs[v].exp_word));
            check($sformatf("v%0d_ch_sel", v), 32'(ch_sel), 32'(vecs[v].ch));
            check($sformatf("v%0d_sgl", v),    32'(single_ended), 32'(vecs[v].sgl));
            check($sformatf("v%0d_oe_mid", v), 32'(oe_mid), 1);
            check($sformatf("v%0d_done", v),   32'(n_done - n0), 1);
            repeat (5) @(negedge clk);
            check($sformatf("v%0d_oe_end", v), 32'(dout_oe), 0);
        end

        // Abort: cs raised after null + 4 data bits
        set_channels(5, 10'h2A5);
        n0 = n_done;
        frame(0, 1'b1, 5, 10, 1'b1, -1, 10'h0, got, oe_mid);
        check("abort_bits", 32'(got[4:0]), 32'(5'b01010));
        repeat (4) @(negedge clk);
        check("abort_oe",   32'(dout_oe), 0);
        check("abort_dout", 32'(dout), 0);
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(n_done - n0), 0);

        // Full frame right after the abort
        set_channels(2, 10'h155);
        n0 = n_done;
        frame(0, 1'b1, 2, 16, 1'b1, -1, 10'h0, got, oe_mid);
        check("post_abort_word", 32'(got[9:0]), 32'(10'b0101010101));
        check("post_abort_done", 32'(n_done - n0), 1);
        repeat (5) @(negedge clk);

        // ch_data changes mid-DATA; the snapshot must be returned
        set_channels(7, 10'h100);
        frame(0, 1'b1, 7, 16, 1'b1, 8, 10'h0FF, got, oe_mid);
        check("snap_word",   32'(got[9:0]), 32'(10'b0100000000));
        check("snap_ch_sel", 32'(ch_sel), 7);
        repeat (5) @(negedge clk);

        // Reset in the middle of a frame (command already decoded)
        set_channels(6, 10'h2C3);
        frame(0, 1'b0, 6, 9, 1'b0, -1, 10'h0, got, oe_mid);
        check("pre_rst_oe", 32'(dout_oe), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_dout",   32'(dout), 0);
        check("mid_rst_oe",     32'(dout_oe), 0);
        check("mid_rst_ch_sel", 32'(ch_sel), 0);
        check("mid_rst_sgl",    32'(single_ended), 0);
        check("mid_rst_done",   32'(conv_done), 0);
        rst = 1'b0;
        cs  = 1'b1;
        repeat (5) @(negedge clk);

        // Frame after reset release
        set_channels(4, 10'h0A5);
        n0 = n_done;
        frame(2, 1'b1, 4, 18, 1'b1, -1, 10'h0, got, oe_mid);
        check("post_rst_word",   32'(got[9:0]), 32'(10'b0010100101));
        check("post_rst_ch_sel", 32'(ch_sel), 4);
        check("post_rst_sgl",    32'(single_ended), 1);
        check("post_rst_done",   32'(n_done - n0), 1);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_adc_responder
`default_nettype wire
